snn_config_loader: RTL and testbench

Upstream configuration stage for the 3-neuron spiking layer. Receives a byte-serial configuration frame over an 8-bit valid/ready bus and assembles the 72-bit input_weights and 32-bit neuron_params words that the layer consumes. Checks the frame with an XOR checksum and commits it atomically, so the layer never sees a partial configuration. Gates the layer's enable while a load is in progress.

---
 rtl/snn_config_loader_if.sv | 10 +
 rtl/snn_config_loader.sv | 125 ++++++++++++
 tb/tb_snn_config_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/snn_config_loader_if.sv
// Byte-serial configuration bus: start pulse plus 8-bit valid/ready transfer.
interface snn_config_loader_if;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;

    modport master (output cfg_start, output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_start, input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/snn_config_loader.sv
// Assembles a byte-serial frame into the spiking layer's weight/parameter words,
// verifies an optional XOR checksum and commits the whole frame atomically.
module snn_config_loader #(
    parameter bit CHECKSUM_EN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    snn_config_loader_if.slave    cfg,
    input  logic                  run_enable,
    output logic [71:0]           input_weights,
    output logic [31:0]           neuron_params,
    output logic                  layer_enable,
    output logic                  config_done,
    output logic                  cfg_error,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_BYTE = 4'd12;

    state_t        state, state_next;
    logic [103:0]  shadow;
    logic [3:0]    byte_cnt;
    logic [7:0]    xor_acc;
    logic [7:0]    tmo_cnt;
    logic          chk_ok;
    logic          loaded;

    logic accepting, restart, xfer, last_byte, timed_out, commit_ok;

    assign accepting = (state == LOAD) || (state == CHECK);
    assign restart   = cfg.cfg_start && (state != COMMIT);
    // A start on the same edge as a valid byte discards that byte.
    assign xfer      = cfg.cfg_valid && accepting && !cfg.cfg_start;
    assign last_byte = (state == LOAD) && xfer && (byte_cnt == LAST_BYTE);
    assign timed_out = accepting && !cfg.cfg_start && !xfer && (tmo_cnt == TMO_LAST);
    assign commit_ok = !CHECKSUM_EN || chk_ok;

    assign cfg.cfg_ready = accepting;
    assign busy          = (state != IDLE);
    assign layer_enable  = run_enable && loaded && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:   if (cfg.cfg_start) state_next = LOAD;
            LOAD: begin
                if (cfg.cfg_start)   state_next = LOAD;
                else if (timed_out)  state_next = IDLE;
                else if (last_byte)  state_next = CHECKSUM_EN ? CHECK : COMMIT;
            end
            CHECK: begin
                if (cfg.cfg_start)   state_next = LOAD;
                else if (timed_out)  state_next = IDLE;
                else if (xfer)       state_next = COMMIT;
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bytes arrive MSB first, so shifting a 13-byte window leaves {weights, params} in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow store is plain flops, so it is reset with everything else.
            shadow        <= '0;
            byte_cnt      <= '0;
            xor_acc       <= '0;
            tmo_cnt       <= '0;
            chk_ok        <= 1'b0;
            loaded        <= 1'b0;
            input_weights <= '0;
            neuron_params <= '0;
            config_done   <= 1'b0;
            cfg_error     <= 1'b0;
        end else begin
            config_done <= 1'b0;
            if (restart) begin
                byte_cnt  <= '0;
                xor_acc   <= '0;
                tmo_cnt   <= '0;
                cfg_error <= 1'b0;
            end else if (accepting) begin
                if (xfer) begin
                    tmo_cnt <= '0;
                    if (state == LOAD) begin
                        shadow   <= {shadow[95:0], cfg.cfg_data};
                        byte_cnt <= byte_cnt + 4'd1;
                        xor_acc  <= xor_acc ^ cfg.cfg_data;
                    end else begin
                        chk_ok <= (cfg.cfg_data == xor_acc);
                    end
                end else if (timed_out) begin
                    tmo_cnt   <= '0;
                    cfg_error <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end else if (state == COMMIT) begin
                if (commit_ok) begin
                    input_weights <= shadow[103:32];
                    neuron_params <= shadow[31:0];
                    loaded        <= 1'b1;
                    config_done   <= 1'b1;
                end else begin
                    cfg_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snn_config_loader.sv
// Directed bench for snn_config_loader: good/bad checksum, gapped transfer,
// timeout, restart and asynchronous reset mid-frame.
module tb_snn_config_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run_enable;
    logic [71:0] input_weights;
    logic [31:0] neuron_params;
    logic layer_enable, config_done, cfg_error, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snn_config_loader_if cfg ();

    snn_config_loader #(.CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg           (cfg.slave),
        .run_enable    (run_enable),
        .input_weights (input_weights),
        .neuron_params (neuron_params),
        .layer_enable  (layer_enable),
        .config_done   (config_done),
        .cfg_error     (cfg_error),
        .busy          (busy)
    );

    // Frame A XORs to 8'h45; frame B XORs to 8'h99.
    localparam logic [103:0] FRAME_A = {72'h010203040506070809, 32'h40050302};
    localparam logic [103:0] FRAME_B = {72'h111213141516171819, 32'h800A0604};
    localparam logic [7:0]   CHK_A   = 8'h45;
    localparam logic [7:0]   CHK_B   = 8'h99;

    task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit with_valid);
        cfg.cfg_start = 1'b1;
        cfg.cfg_valid = with_valid;
        cfg.cfg_data  = 8'hEE;
        tick();
        cfg.cfg_start = 1'b0;
        cfg.cfg_valid = 1'b0;
    endtask

    // Sends the first n bytes of frame f (index 13 is the checksum byte chk).
    task automatic send_frame(input logic [103:0] f, input logic [7:0] chk, input int n,
                              input bit gaps, input bit watch);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = (k < 13) ? f[103 - 8*k -: 8] : chk;
            if (gaps) begin
                cfg.cfg_valid = 1'b0;
                if (watch) begin
                    check("ready_gap", cfg.cfg_ready, 1);
                    check("layer_en_gap", layer_enable, 0);
                end
                tick();
            end
            cfg.cfg_valid = 1'b1;
            cfg.cfg_data  = b;
            if (watch) begin
                check("ready_load", cfg.cfg_ready, 1);
                check("layer_en_load", layer_enable, 0);
            end
            tick();
        end
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg.cfg_start = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_data  = 8'h00;
        run_enable    = 1'b1;
        #12 rst_n = 1'b1;
        tick();

        // Reset state with run requested but nothing loaded
        check("rst_layer_en", layer_enable, 0);
        check("rst_weights", input_weights, 0);
        check("rst_params", neuron_params, 0);
        check("rst_error", cfg_error, 0);
        check("rst_ready", cfg.cfg_ready, 0);
        check("rst_busy", busy, 0);

        // Back-to-back good frame: outputs change 2 edges after the checksum byte
        pulse_start(1'b0);
        send_frame(FRAME_A, CHK_A, 14, 1'b0, 1'b1);
        check("a_commit_busy", busy, 1);
        check("a_commit_done", config_done, 0);
        check("a_commit_old_w", input_weights, 0);
        tick();
        check("a_weights", input_weights, 72'h010203040506070809);
        check("a_params", neuron_params, 32'h40050302);
        check("a_done", config_done, 1);
        check("a_busy", busy, 0);
        check("a_layer_en", layer_enable, 1);
        tick();
        check("a_done_drop", config_done, 0);
        check("a_layer_en_hold", layer_enable, 1);

        // Bad checksum: error set, prior config kept
        pulse_start(1'b0);
        send_frame(FRAME_B, CHK_B ^ 8'h01, 14, 1'b0, 1'b0);
        tick();
        check("bad_error", cfg_error, 1);
        check("bad_done", config_done, 0);
        check("bad_weights", input_weights, 72'h010203040506070809);
        check("bad_params", neuron_params, 32'h40050302);
        tick();
        check("bad_done_later", config_done, 0);
        pulse_start(1'b0);
        check("start_clears_error", cfg_error, 0);

        // Gapped transfer of frame B on that same start
        send_frame(FRAME_B, CHK_B, 14, 1'b1, 1'b1);
        tick();
        check("b_weights", input_weights, 72'h111213141516171819);
        check("b_params", neuron_params, 32'h800A0604);
        check("b_done", config_done, 1);
        tick();

        // Timeout: 5 bytes then idle
        pulse_start(1'b0);
        send_frame(FRAME_A, CHK_A, 5, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("tmo_error_early", cfg_error, 0);
        check("tmo_busy_early", busy, 1);
        tick();
        check("tmo_error", cfg_error, 1);
        check("tmo_busy", busy, 0);
        check("tmo_weights", input_weights, 72'h111213141516171819);
        check("tmo_done", config_done, 0);

        // Restart after 6 bytes; the byte offered with the restart is dropped
        pulse_start(1'b0);
        send_frame(FRAME_B, CHK_B, 6, 1'b0, 1'b0);
        pulse_start(1'b1);
        send_frame(FRAME_A, CHK_A, 14, 1'b0, 1'b0);
        tick();
        check("rs_weights", input_weights, 72'h010203040506070809);
        check("rs_params", neuron_params, 32'h40050302);
        check("rs_done", config_done, 1);
        check("rs_error", cfg_error, 0);
        tick();

        // Asynchronous reset in the middle of a frame
        pulse_start(1'b0);
        send_frame(FRAME_B, CHK_B, 4, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_weights", input_weights, 0);
        check("arst_params", neuron_params, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", cfg.cfg_ready, 0);
        check("arst_layer_en", layer_enable, 0);
        #5 rst_n = 1'b1;
        tick();
        check("arst_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
